// File: rtl/lpddr2_arbiter.sv
`timescale 1ns/1ps
// lpddr2_arbiter: two-port (CPU / disk DMA) round-robin arbiter that
// serialises single-word read/write transactions onto the LPDDR2 wrapper.
// Each transaction walks IDLE -> ISSUE -> WAIT -> RESP. A 16-bit watchdog
// in WAIT aborts a transaction that never sees m_done.
module lpddr2_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              p0_rreq,
    input  logic              p0_wreq,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic              p0_err,
    input  logic              p1_rreq,
    input  logic              p1_wreq,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic              p1_err,
    output logic [DATA_W-1:0] rdata,
    output logic              m_rreq,
    output logic              m_wreq,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_done,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy,
    output logic              grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

    state_t            state_reg, state_next;
    logic [15:0]       timer_reg, timer_next;
    logic              last_grant_reg, last_grant_next;
    logic              grant_reg, grant_next;
    logic              err_reg, err_next;
    logic              op_wr_reg, op_wr_next;
    logic              just_resp_reg;
    logic [ADDR_W-1:0] m_addr_reg, m_addr_next;
    logic [DATA_W-1:0] m_wdata_reg, m_wdata_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;

    logic [1:0]        req_rd, req_wr, req_any, eligible, ack_vec, err_vec;
    logic [ADDR_W-1:0] req_addr  [2];
    logic [DATA_W-1:0] req_wdata [2];
    logic              winner;

    assign req_rd       = {p1_rreq, p0_rreq};
    assign req_wr       = {p1_wreq, p0_wreq};
    assign req_addr[0]  = p0_addr;
    assign req_addr[1]  = p1_addr;
    assign req_wdata[0] = p0_wdata;
    assign req_wdata[1] = p1_wdata;

    // A port that was just acknowledged is masked for one IDLE evaluation so
    // a request line that has not yet dropped is not served twice.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign req_any[gi]  = req_rd[gi] | req_wr[gi];
            assign eligible[gi] = req_any[gi] & ~(just_resp_reg & (last_grant_reg == 1'(gi)));
            assign ack_vec[gi]  = (state_reg == RESP) & (grant_reg == 1'(gi));
            assign err_vec[gi]  = ack_vec[gi] & err_reg;
        end
    endgenerate

    // Both eligible: the port that did not go last wins; otherwise the lone requester.
    assign winner = (eligible == 2'b11) ? ~last_grant_reg : eligible[1];

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_reg      <= IDLE;
            timer_reg      <= '0;
            last_grant_reg <= 1'b1;
            grant_reg      <= 1'b0;
            err_reg        <= 1'b0;
            op_wr_reg      <= 1'b0;
            just_resp_reg  <= 1'b0;
            m_addr_reg     <= '0;
            m_wdata_reg    <= '0;
            rdata_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            timer_reg      <= timer_next;
            last_grant_reg <= last_grant_next;
            grant_reg      <= grant_next;
            err_reg        <= err_next;
            op_wr_reg      <= op_wr_next;
            just_resp_reg  <= (state_reg == RESP);
            m_addr_reg     <= m_addr_next;
            m_wdata_reg    <= m_wdata_next;
            rdata_reg      <= rdata_next;
        end
    end

    // Next-state logic and the one-cycle memory request strobes.
    always_comb begin
        state_next      = state_reg;
        timer_next      = timer_reg;
        last_grant_next = last_grant_reg;
        grant_next      = grant_reg;
        err_next        = err_reg;
        op_wr_next      = op_wr_reg;
        m_addr_next     = m_addr_reg;
        m_wdata_next    = m_wdata_reg;
        rdata_next      = rdata_reg;
        m_rreq          = 1'b0;
        m_wreq          = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|eligible) begin
                    grant_next   = winner;
                    m_addr_next  = req_addr[winner];
                    m_wdata_next = req_wdata[winner];
                    op_wr_next   = req_wr[winner];
                    state_next   = ISSUE;
                end
            end
            ISSUE: begin
                m_rreq     = ~op_wr_reg;
                m_wreq     = op_wr_reg;
                timer_next = '0;
                state_next = WAIT;
            end
            WAIT: begin
                if (m_done) begin
                    if (!op_wr_reg) begin
                        rdata_next = m_rdata;
                    end
                    err_next   = 1'b0;
                    state_next = RESP;
                end else if (timer_reg == TIMER_LAST) begin
                    err_next   = 1'b1;
                    state_next = RESP;
                end else begin
                    timer_next = timer_reg + 16'd1;
                end
            end
            RESP: begin
                last_grant_next = grant_reg;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign p0_ack  = ack_vec[0];
    assign p1_ack  = ack_vec[1];
    assign p0_err  = err_vec[0];
    assign p1_err  = err_vec[1];
    assign rdata   = rdata_reg;
    assign m_addr  = m_addr_reg;
    assign m_wdata = m_wdata_reg;
    assign busy    = (state_reg != IDLE);
    assign grant   = grant_reg;

endmodule

// File: doc/lpddr2_arbiter.md
LPDDR2_ARBITER -- requirements
Module: lpddr2_arbiter

Interface
REQ-001 Param ADDR_W, default 32, address width for both ports and the memory side.
REQ-002 Param DATA_W, default 32, data width for both ports and the memory side.
REQ-003 Param TIMEOUT, default 1024, cycles in WAIT before a transaction aborts (range 2..65535).
REQ-004 iCLK  in  1  single clock (afi_half_clk domain); all logic on rising edge.
REQ-005 iRST_n  in  1  asynchronous, active-low reset.
REQ-006 pN_rreq, pN_wreq  in  1 each  port N (N=0 CPU, N=1 disk DMA) read/write request, level, held until pN_ack.
REQ-007 pN_addr  in  ADDR_W  port N word address, stable while request held.
REQ-008 pN_wdata  in  DATA_W  port N write data, stable while pN_wreq held.
REQ-009 pN_ack  out  1  one-cycle completion pulse to port N.
REQ-010 pN_err  out  1  high with pN_ack when the transaction timed out.
REQ-011 rdata  out  DATA_W  read data register shared by both ports, valid during pN_ack of a read.
REQ-012 m_rreq, m_wreq  out  1 each  one-cycle request strobes to the LPDDR2 memory wrapper.
REQ-013 m_addr  out  ADDR_W; m_wdata  out  DATA_W  latched transaction fields to the memory wrapper.
REQ-014 m_done  in  1  one-cycle completion strobe from the memory wrapper; m_rdata  in  DATA_W valid with it.
REQ-015 busy  out  1  high in any state other than IDLE; grant  out  1  port currently owning the memory.

Function
REQ-016 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP, encoded in 2 bits.
REQ-017 IDLE: if any port requests, the FSM SHALL choose a winner, latch its addr/wdata/op into m_addr/m_wdata/op, set grant, and go to ISSUE.
REQ-018 Arbitration: round-robin on last_grant; with both ports requesting, the port != last_grant wins; with one port requesting, that port wins.
REQ-019 If pN_rreq and pN_wreq are both high, the arbiter SHALL perform a write; the read request is ignored.
REQ-020 ISSUE: the FSM SHALL assert exactly one of m_rreq/m_wreq for exactly one cycle, clear the timer, and go to WAIT.
REQ-021 WAIT: on m_done, capture m_rdata into rdata (reads only) and go to RESP with err=0.
REQ-022 WAIT: the timer (16-bit) SHALL increment each cycle without m_done; when it reaches TIMEOUT-1, go to RESP with err=1 and leave rdata unchanged.
REQ-023 If m_done and timeout coincide, m_done SHALL take priority (err=0).
REQ-024 RESP: pulse pgrant_ack (and pgrant_err if err) for one cycle, set last_grant=grant, return to IDLE.
REQ-025 m_done outside WAIT SHALL be ignored.
REQ-026 m_addr/m_wdata SHALL stay constant from ISSUE through RESP.
REQ-027 A request dropped before ack SHALL NOT abort the transaction; ack still pulses.
REQ-028 A port SHALL NOT be re-granted in the IDLE cycle that follows its own RESP; its still-high request waits one IDLE evaluation, preventing double service of the same request.
REQ-029 Latency: a request seen in IDLE at cycle T gives m_*req at T+1; m_done at cycle D (D>=T+2) gives ack at D+1; minimum request-to-ack = 3 cycles.
REQ-030 The non-granted port's ack/err SHALL remain 0 throughout.

Reset
REQ-031 On iRST_n low (asynchronous, also mid-transaction): state=IDLE, timer=0, last_grant=1, grant=0, err=0, and all outputs 0 (pN_ack, pN_err, m_rreq, m_wreq, m_addr, m_wdata, rdata, busy).
REQ-032 After iRST_n release, the first arbitration with both ports requesting SHALL grant port 0; no ack for a transaction aborted by reset.

Verification
REQ-033 p0 read addr 0x10, m_done 2 cycles after m_rreq with m_rdata 0xDEADBEEF -> m_rreq 1 cycle, p0_ack 1 cycle, rdata=0xDEADBEEF, p0_err=0.
REQ-034 p0 and p1 writes held simultaneously from reset -> p0 served first, then p1, then p0 again if still requesting; no back-to-back grants to the same port while the other waits.
REQ-035 p1 write, m_done never arrives, TIMEOUT=8 -> p1_ack and p1_err high 8 cycles after entering WAIT; rdata unchanged; arbiter returns to IDLE.
REQ-036 m_done on the cycle the timer hits TIMEOUT-1 -> ack with err=0; stray m_done in IDLE -> no ack.
REQ-037 iRST_n pulsed low during WAIT -> all outputs 0 immediately; no ack; p0 request re-arbitrated after release.
REQ-038 p0 rreq and wreq both high -> m_wreq only, m_wdata=p0_wdata.
